// File: rtl/sync_fifo_reader_if.sv
// ============================================================================
// Module      : sync_fifo_reader_if
// Description : FIFO read-port and downstream valid/ready bundle for
//               sync_fifo_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sync_fifo_reader_if #(
  parameter int WIDTH = 16
);
  logic             fifo_read;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data_out;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output fifo_read,
    output out_data,
    output out_valid,
    input  fifo_empty,
    input  fifo_data_out,
    input  out_ready
  );

  modport slave (
    input  fifo_read,
    input  out_data,
    input  out_valid,
    output fifo_empty,
    output fifo_data_out,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/sync_fifo_reader.sv
// ============================================================================
// Module      : sync_fifo_reader
// Description : Drains a synchronous FIFO into a valid/ready stream through a
//               2-entry skid buffer that hides the FIFO's 1-cycle read latency.
//               Optional delivered-word counter: SYNC_FIFO_READER_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_reader #(
  parameter int WIDTH = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          en,
  sync_fifo_reader_if.master bus
`ifdef SYNC_FIFO_READER_CNT_EN
  ,
  output logic [15:0]        word_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } flow_t;

  flow_t            r_state;
  logic             r_inflight;
  logic             r_valid;
  logic [WIDTH-1:0] r_buf0;
  logic [WIDTH-1:0] r_buf1;

  logic             w_pop;
  logic [2:0]       w_level;
  logic             w_slot1;

  assign w_pop   = r_valid && bus.out_ready;
  // Occupancy the buffer will reach once the pending read lands and this pop leaves.
  assign w_level = {1'b0, r_state} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_slot1 = (r_state == S_TWO) || ((r_state == S_ONE) && !w_pop);

  assign bus.fifo_read = !rst && en && !bus.fifo_empty && (w_level < 3'd2);
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_buf0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_inflight <= bus.fifo_read;

      if (w_pop && (r_state == S_TWO)) begin
        r_buf0 <= r_buf1;
      end

      if (r_inflight) begin
        if (w_slot1) begin
          r_buf1 <= bus.fifo_data_out;
        end else begin
          r_buf0 <= bus.fifo_data_out;
        end
      end

      case (r_state)
        S_EMPTY: begin
          if (r_inflight) begin
            r_state <= S_ONE;
            r_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (r_inflight && !w_pop) begin
            r_state <= S_TWO;
          end else if (!r_inflight && w_pop) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
          end
        end
        S_TWO: begin
          if (w_pop && !r_inflight) begin
            r_state <= S_ONE;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYNC_FIFO_READER_CNT_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_cnt <= 16'h0000;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 16'h0001;
    end
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: emulated FIFO, queue-based skid-buffer model,
// directed scenarios plus a randomized stream.
`default_nettype none

module tb_sync_fifo_reader;

  logic clk = 1'b0;
  logic rst;
  logic en;
`ifdef SYNC_FIFO_READER_CNT_EN
  logic [15:0] word_cnt;
`endif

  always #5 clk = ~clk;

  sync_fifo_reader_if #(.WIDTH(16)) bus ();

  sync_fifo_reader #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
`ifdef SYNC_FIFO_READER_CNT_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  logic [15:0] fq[$];
  logic [15:0] mb[$];
  logic [15:0] got[$];
  logic [15:0] sent[$];
  logic [15:0] m_last = 16'h0000;
  bit          m_inf  = 1'b0;
  bit          s_rd   = 1'b0;
  bit          chk_on = 1'b0;
  int          n_reads = 0;
  int          n_got   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Compare process: the buffer model's expectation against the DUT each cycle.
  always @(negedge clk) begin
    bit          e_valid;
    bit          e_pop;
    bit          e_rd;
    logic [15:0] e_data;
    s_rd = bus.fifo_read;
    if (chk_on) begin
      e_valid = (mb.size() != 0);
      e_data  = e_valid ? mb[0] : m_last;
      e_pop   = e_valid && bus.out_ready;
      e_rd    = en && !bus.fifo_empty && ((mb.size() + int'(m_inf) - int'(e_pop)) < 2);
      check("fifo_read", 32'(bus.fifo_read), 32'(e_rd));
      check("out_valid", 32'(bus.out_valid), 32'(e_valid));
      check("out_data", 32'(bus.out_data), 32'(e_data));
      check("read_on_empty", 32'(bus.fifo_read && bus.fifo_empty), 32'd0);
    end
  end

  task automatic tick();
    logic [15:0] cap;
    bit          pop;
    @(posedge clk);
    #1;
    cap = bus.fifo_data_out;
    pop = (mb.size() != 0) && bus.out_ready;
    if (pop) begin
      m_last = mb.pop_front();
      got.push_back(m_last);
      n_got++;
    end
    if (m_inf) mb.push_back(cap);
    m_inf = s_rd;
    if (s_rd) begin
      n_reads++;
      if (fq.size() != 0) bus.fifo_data_out = fq.pop_front();
    end
    bus.fifo_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic model_clear();
    mb.delete();
    m_inf  = 1'b0;
    m_last = 16'h0000;
  endtask

  initial begin
    int errs;
    rst               = 1'b1;
    en                = 1'b0;
    bus.fifo_empty    = 1'b1;
    bus.fifo_data_out = 16'h0000;
    bus.out_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_fifo_read", 32'(bus.fifo_read), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
`ifdef SYNC_FIFO_READER_CNT_EN
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
`endif
    rst = 1'b0;
    model_clear();
    chk_on = 1'b1;
    en = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) tick();

    // Three pre-loaded words, free-flowing downstream.
    push(16'h0007); push(16'h0008); push(16'h0009);
    n_reads = 0; got.delete();
    tick(); tick();
    check("first_word_valid", 32'(bus.out_valid), 32'd1);
    check("first_word_data", 32'(bus.out_data), 32'h0007);
    repeat (6) tick();
    check("a_reads", 32'(n_reads), 32'd3);
    check("a_count", 32'(got.size()), 32'd3);
    check("a_w0", 32'(got[0]), 32'h0007);
    check("a_w1", 32'(got[1]), 32'h0008);
    check("a_w2", 32'(got[2]), 32'h0009);
    check("a_idle_valid", 32'(bus.out_valid), 32'd0);

    // Stalled downstream: only two reads fit the skid buffer.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h0A00 + 16'(i));
    n_reads = 0; got.delete();
    repeat (6) tick();
    check("b_reads", 32'(n_reads), 32'd2);
    check("b_read_low", 32'(bus.fifo_read), 32'd0);
    check("b_head", 32'(bus.out_data), 32'h0A00);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("b_no_gap", 32'(got.size()), 32'd4);
    errs = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== 16'h0A00 + 16'(i)) errs++;
    check("b_order", 32'(errs), 32'd0);

    // Downstream ready toggling every cycle.
    for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
    got.delete();
    for (int i = 0; i < 30; i++) begin
      tick();
      bus.out_ready = ~bus.out_ready;
    end
    check("c_count", 32'(got.size()), 32'd10);
    errs = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== 16'h0100 + 16'(i)) errs++;
    check("c_order", 32'(errs), 32'd0);

    // Enable dropped with a read in flight.
    bus.out_ready = 1'b1;
    repeat (2) tick();
    push(16'h0D00); push(16'h0D01);
    n_reads = 0; got.delete();
    tick();
    en = 1'b0;
    repeat (5) tick();
    check("d_reads", 32'(n_reads), 32'd1);
    check("d_inflight_kept", 32'(got.size()), 32'd1);
    check("d_word0", 32'(got[0]), 32'h0D00);
    en = 1'b1;
    repeat (4) tick();
    check("d_resume", 32'(got.size()), 32'd2);
    check("d_word1", 32'(got[1]), 32'h0D01);

    // Randomized traffic, then drain and compare against everything pushed.
    got.delete(); sent.delete();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) begin
        logic [15:0] w;
        w = 16'($urandom);
        push(w);
        sent.push_back(w);
      end
      en            = ($urandom_range(4) != 0);
      bus.out_ready = $urandom_range(1) == 1;
      tick();
    end
    en = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 500 && fq.size() != 0; i++) tick();
    repeat (6) tick();
    check("e_count", 32'(got.size()), 32'(sent.size()));
    errs = 0;
    for (int i = 0; i < got.size() && i < sent.size(); i++) if (got[i] !== sent[i]) errs++;
    check("e_order", 32'(errs), 32'd0);

    // Asynchronous reset with a full buffer.
    bus.out_ready = 1'b0;
    push(16'h0C00); push(16'h0C01); push(16'h0C02);
    repeat (4) tick();
    check("f_full_valid", 32'(bus.out_valid), 32'd1);
    chk_on = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("f_rst_valid", 32'(bus.out_valid), 32'd0);
    check("f_rst_read", 32'(bus.fifo_read), 32'd0);
    check("f_rst_data", 32'(bus.out_data), 32'd0);
    repeat (2) tick();
    check("f_rst_read_held", 32'(bus.fifo_read), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_clear();
    chk_on = 1'b1;
    bus.out_ready = 1'b1;
    got.delete();
    repeat (5) tick();
    check("f_after_count", 32'(got.size()), 32'd1);
    check("f_after_word", 32'(got[0]), 32'h0C02);

`ifdef SYNC_FIFO_READER_CNT_EN
    chk_on = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #3 rst = 1'b0;
    model_clear();
    chk_on = 1'b1;
    n_got = 0;
    for (int i = 0; i < 5; i++) push(16'h0E00 + 16'(i));
    for (int i = 0; i < 20 && n_got < 5; i++) tick();
    check("g_cnt5", 32'(word_cnt), 32'd5);
    for (int i = 0; i < 70000 && n_got < 65536; i++) begin
      if (fq.size() + n_got < 65536 && fq.size() < 2) push(16'(i));
      tick();
      got.delete();
    end
    check("g_delivered", 32'(n_got), 32'd65536);
    check("g_wrap", 32'(word_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
